// File: rtl/pimc_irq_rx_if.sv
// Purpose : bundles the PIMC notify/ack pair and the core-side interrupt delivery bus.
// Latency : n/a (wiring only).
// Backpressure: PIMC holds notify/lineno until irqack; core pops via irq_valid && irq_taken.
//
// Ports (signals):
//   notify, lineno           PIMC -> receiver, active-low message pending + line number
//   irqack                   receiver -> PIMC, one-cycle re-arm pulse
//   irq_en, ivt_base         core -> receiver, delivery gate and interrupt table base
//   irq_valid, irq_lineno,
//   irq_vector               receiver -> core, queue head
//   irq_taken                core -> receiver, accept head
//   mask_we, mask_wdata,
//   drop_clr, irq_dropped    present only when IRQ_MASK_EN is defined
// modport slave is the receiver's view; modport master is the surrounding system's view.
interface pimc_irq_rx_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int MASK_LINES = 32
);
   logic                  notify;
   logic [7:0]            lineno;
   logic                  irqack;
   logic                  irq_en;
   logic [ADDR_WIDTH-1:0] ivt_base;
   logic                  irq_valid;
   logic [7:0]            irq_lineno;
   logic [ADDR_WIDTH-1:0] irq_vector;
   logic                  irq_taken;
`ifdef IRQ_MASK_EN
   logic                  mask_we;
   logic [MASK_LINES-1:0] mask_wdata;
   logic                  drop_clr;
   logic                  irq_dropped;

   modport slave (
      input  notify, lineno, irq_en, ivt_base, irq_taken, mask_we, mask_wdata, drop_clr,
      output irqack, irq_valid, irq_lineno, irq_vector, irq_dropped
   );
   modport master (
      output notify, lineno, irq_en, ivt_base, irq_taken, mask_we, mask_wdata, drop_clr,
      input  irqack, irq_valid, irq_lineno, irq_vector, irq_dropped
   );
`else
   modport slave (
      input  notify, lineno, irq_en, ivt_base, irq_taken,
      output irqack, irq_valid, irq_lineno, irq_vector
   );
   modport master (
      output notify, lineno, irq_en, ivt_base, irq_taken,
      input  irqack, irq_valid, irq_lineno, irq_vector
   );
`endif
endinterface

// File: rtl/pimc_irq_rx.sv
// Purpose : PIMC interrupt receiver; captures notified lines into an in-order queue and delivers them to the core.
// Latency : irqack one cycle after capture; queued line visible on irq_* the cycle after capture.
// Backpressure: queue full -> no capture, no ack, PIMC holds its message; irq_en=0 holds the queue.
//
// Ports:
//   clk   system clock
//   rst   asynchronous reset, active-high
//   bus   pimc_irq_rx_if.slave (PIMC notify/lineno/irqack, core irq_* delivery, optional mask controls)
// Optional feature: define IRQ_MASK_EN to add the per-line mask register and sticky irq_dropped flag.
module pimc_irq_rx #(
   parameter int FIFO_DEPTH     = 4,
   parameter int IRQTAB_ENTSIZE = 8,
   parameter int ADDR_WIDTH     = 64,
   parameter int MASK_LINES     = 32
) (
   input  logic         clk,
   input  logic         rst,
   pimc_irq_rx_if.slave bus
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [ADDR_WIDTH-1:0] ENT_SIZE  = ADDR_WIDTH'(IRQTAB_ENTSIZE);
   localparam logic [CW-1:0]         DEPTH_CNT = CW'(FIFO_DEPTH);

   // Pointers wrap by natural overflow, so the depth must be a power of two.
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MASK_LINES < 1) begin : g_bad_param
      $error("pimc_irq_rx: FIFO_DEPTH must be a power of 2 >= 2 and MASK_LINES >= 1");
   end

   typedef enum logic [1:0] {
      ST_ARM,
      ST_IDLE,
      ST_REARM
   } state_t;

   state_t        state_q, state_d;
   logic          irqack_q, irqack_d;
   logic [7:0]    fifo_q [FIFO_DEPTH];
   logic [7:0]    fifo_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic          empty;
   logic          full;
   logic          push;
   logic          pop;
   logic          irq_valid;
   logic          line_masked;
   logic          drop_set;
   logic [7:0]    head_line;

   assign empty     = (count_q == '0);
   assign full      = (count_q == DEPTH_CNT);
   assign head_line = fifo_q[rd_ptr_q];
   assign irq_valid = !empty && bus.irq_en;
   assign pop       = irq_valid && bus.irq_taken;

   assign bus.irqack     = irqack_q;
   assign bus.irq_valid  = irq_valid;
   assign bus.irq_lineno = empty ? 8'd0 : head_line;
   // Zero-extend before scaling; the add wraps modulo 2^ADDR_WIDTH.
   assign bus.irq_vector = empty ? '0 : (bus.ivt_base + ADDR_WIDTH'(head_line) * ENT_SIZE);

`ifdef IRQ_MASK_EN
   logic [MASK_LINES-1:0] mask_q, mask_d;
   logic [MASK_LINES-1:0] mask_shift;
   logic                  dropped_q, dropped_d;

   // Shift instead of indexing so out-of-range line numbers never form a bad select.
   assign mask_shift  = mask_q >> bus.lineno;
   assign line_masked = (int'(bus.lineno) < MASK_LINES) && mask_shift[0];
   assign bus.irq_dropped = dropped_q;

   always_comb begin
      mask_d    = mask_q;
      dropped_d = dropped_q;
      if (bus.mask_we) begin
         mask_d = bus.mask_wdata;
      end
      if (bus.drop_clr) begin
         dropped_d = 1'b0;
      end
      // A drop in the same cycle as a clear must remain visible.
      if (drop_set) begin
         dropped_d = 1'b1;
      end
   end
`else
   assign line_masked = 1'b0;
`endif

   // Capture FSM: one ack per notify episode, then wait for the PIMC to drop notify.
   always_comb begin
      state_d  = state_q;
      irqack_d = 1'b0;
      push     = 1'b0;
      drop_set = 1'b0;
      case (state_q)
         ST_ARM: begin
            // PIMC powers up unarmed; one unsolicited ack lets it present pending lines.
            irqack_d = 1'b1;
            state_d  = ST_REARM;
         end
         ST_IDLE: begin
            if (!bus.notify) begin
               if (line_masked) begin
                  // Masked lines are consumed even when the queue is full.
                  irqack_d = 1'b1;
                  drop_set = 1'b1;
                  state_d  = ST_REARM;
               end else if (!full) begin
                  // Full is checked before any same-cycle pop.
                  push     = 1'b1;
                  irqack_d = 1'b1;
                  state_d  = ST_REARM;
               end
            end
         end
         ST_REARM: begin
            if (bus.notify) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_ARM;
         end
      endcase
   end

   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      if (push) begin
         fifo_d[wr_ptr_q] = bus.lineno;
         wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_ARM;
         irqack_q  <= 1'b0;
         fifo_q    <= '{default: 8'd0};
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
`ifdef IRQ_MASK_EN
         mask_q    <= '0;
         dropped_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         irqack_q  <= irqack_d;
         fifo_q    <= fifo_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
`ifdef IRQ_MASK_EN
         mask_q    <= mask_d;
         dropped_q <= dropped_d;
`endif
      end
   end

endmodule

// File: tb/tb_pimc_irq_rx.sv
// Purpose : self-checking bench for pimc_irq_rx; directed PIMC/core stimulus with a delivery scoreboard.
// Latency : n/a.
// Backpressure: the PIMC model holds notify until irqack; the monitor pops expectations on irq_valid && irq_taken.
module tb_pimc_irq_rx;

   typedef struct {
      logic [7:0]  ln;
      logic [63:0] vec;
   } exp_t;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;
   logic ack_prev;
   exp_t exp_q[$];

   pimc_irq_rx_if #(.ADDR_WIDTH(64), .MASK_LINES(32)) bus ();

   pimc_irq_rx #(
      .FIFO_DEPTH(4),
      .IRQTAB_ENTSIZE(8),
      .ADDR_WIDTH(64),
      .MASK_LINES(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // PIMC model: present a line and hold it until acknowledged.
   task automatic issue(input logic [7:0] ln, input logic [63:0] vec, input bit enq);
      exp_t e;
      if (enq) begin
         e.ln  = ln;
         e.vec = vec;
         exp_q.push_back(e);
      end
      bus.notify = 1'b0;
      bus.lineno = ln;
   endtask

   task automatic wait_ack(input logic [7:0] ln);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (bus.irqack) got = 1'b1;
      end
      n_chk++;
      if (!got) begin
         n_fail++;
         $display("FAIL ack_timeout line %0d: irqack=0 after 20 cycles, expected a pulse", ln);
      end
      @(posedge clk);
      #1 bus.notify = 1'b1;
      step();
   endtask

   task automatic deliver(input logic [7:0] ln, input logic [63:0] vec, input bit enq);
      issue(ln, vec, enq);
      wait_ack(ln);
   endtask

   task automatic drain();
      bus.irq_taken = 1'b1;
      for (int i = 0; i < 30 && bus.irq_valid; i++) step();
      bus.irq_taken = 1'b0;
      chk("drain_empty", 64'(bus.irq_valid), 64'd0);
   endtask

   // Monitor: checks each delivered head against the scoreboard and the ack pulse width.
   always @(negedge clk) begin
      if (rst) begin
         ack_prev = 1'b0;
      end else begin
         if (bus.irqack) begin
            n_chk++;
            if (ack_prev) begin
               n_fail++;
               $display("FAIL irqack_double: irqack=1 on two consecutive cycles, expected single pulse");
            end
         end
         ack_prev = bus.irqack;
         if (bus.irq_valid && bus.irq_taken) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_pop: line %0d delivered, expected queue empty", bus.irq_lineno);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (bus.irq_lineno !== e.ln || bus.irq_vector !== e.vec) begin
                  n_fail++;
                  $display("FAIL pop_order: got line %0d vec 0x%0h, expected line %0d vec 0x%0h",
                           bus.irq_lineno, bus.irq_vector, e.ln, e.vec);
               end
            end
         end
      end
   end

   initial begin
      n_chk         = 0;
      n_fail        = 0;
      ack_prev      = 1'b0;
      rst           = 1'b1;
      bus.notify    = 1'b1;
      bus.lineno    = 8'd0;
      bus.irq_en    = 1'b0;
      bus.ivt_base  = 64'h1000;
      bus.irq_taken = 1'b0;
`ifdef IRQ_MASK_EN
      bus.mask_we    = 1'b0;
      bus.mask_wdata = '0;
      bus.drop_clr   = 1'b0;
`endif

      // 1: reset values, then a single ARM pulse right after release.
      step();
      step();
      chk("rst_irqack", 64'(bus.irqack), 64'd0);
      chk("rst_irq_valid", 64'(bus.irq_valid), 64'd0);
      chk("rst_irq_lineno", 64'(bus.irq_lineno), 64'd0);
      chk("rst_irq_vector", bus.irq_vector, 64'd0);
      rst = 1'b0;
      step();
      chk("arm_pulse", 64'(bus.irqack), 64'd1);
      step();
      chk("arm_pulse_end", 64'(bus.irqack), 64'd0);
      chk("arm_no_valid", 64'(bus.irq_valid), 64'd0);
      step();

      // 2: single line, vector = 0x1000 + 5*8.
      bus.irq_en = 1'b1;
      deliver(8'd5, 64'h1028, 1'b1);
      chk("t2_valid", 64'(bus.irq_valid), 64'd1);
      chk("t2_lineno", 64'(bus.irq_lineno), 64'd5);
      chk("t2_vector", bus.irq_vector, 64'h1028);
      bus.irq_taken = 1'b1;
      step();
      bus.irq_taken = 1'b0;
      chk("t2_popped", 64'(bus.irq_valid), 64'd0);

      // 3: fill the queue, line 9 must wait until one entry is taken.
      deliver(8'd1, 64'h1008, 1'b1);
      deliver(8'd2, 64'h1010, 1'b1);
      deliver(8'd3, 64'h1018, 1'b1);
      deliver(8'd4, 64'h1020, 1'b1);
      issue(8'd9, 64'h1048, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t3_no_ack_full", 64'(bus.irqack), 64'd0);
      end
      chk("t3_head_while_full", 64'(bus.irq_lineno), 64'd1);
      bus.irq_taken = 1'b1;
      step();
      bus.irq_taken = 1'b0;
      wait_ack(8'd9);
      drain();

      // 4: irq_en=0 holds the queue and ignores irq_taken.
      bus.irq_en = 1'b0;
      deliver(8'd3, 64'h1018, 1'b1);
      deliver(8'd6, 64'h1030, 1'b1);
      bus.irq_taken = 1'b1;
      step();
      chk("t4_gated_valid", 64'(bus.irq_valid), 64'd0);
      step();
      chk("t4_gated_valid2", 64'(bus.irq_valid), 64'd0);
      bus.irq_taken = 1'b0;
      bus.irq_en    = 1'b1;
      #1;
      chk("t4_enabled_valid", 64'(bus.irq_valid), 64'd1);
      chk("t4_head", 64'(bus.irq_lineno), 64'd3);
      drain();

      // 5: vector wraps modulo 2^64.
      bus.ivt_base = 64'hFFFF_FFFF_FFFF_FFF8;
      deliver(8'd2, 64'h8, 1'b1);
      chk("t5_wrap_vector", bus.irq_vector, 64'h8);
      bus.irq_taken = 1'b1;
      step();
      bus.irq_taken = 1'b0;

      // 5b: reset while acknowledging a capture discards everything.
      issue(8'd7, 64'h0, 1'b0);
      step();
      chk("t5_in_rearm_ack", 64'(bus.irqack), 64'd1);
      rst        = 1'b1;
      bus.notify = 1'b1;
      #1;
      chk("t5_rst_valid", 64'(bus.irq_valid), 64'd0);
      chk("t5_rst_irqack", 64'(bus.irqack), 64'd0);
      step();
      rst = 1'b0;
      step();
      chk("t5_arm_after_rst", 64'(bus.irqack), 64'd1);
      step();
      chk("t5_arm_end", 64'(bus.irqack), 64'd0);
      chk("t5_queue_empty", 64'(bus.irq_valid), 64'd0);
      step();
      bus.ivt_base = 64'h1000;
      deliver(8'd4, 64'h1020, 1'b1);
      drain();

`ifdef IRQ_MASK_EN
      // 6: masked line is acked, dropped, and not enqueued.
      bus.mask_we    = 1'b1;
      bus.mask_wdata = 32'h0000_0080;
      step();
      bus.mask_we = 1'b0;
      deliver(8'd7, 64'h0, 1'b0);
      chk("t6_not_enqueued", 64'(bus.irq_valid), 64'd0);
      chk("t6_dropped", 64'(bus.irq_dropped), 64'd1);
      bus.drop_clr = 1'b1;
      step();
      bus.drop_clr = 1'b0;
      chk("t6_drop_clr", 64'(bus.irq_dropped), 64'd0);
`endif

      repeat (3) step();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
